pc_fetch: RTL
=============

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter: RESET_IP, default 32'h0000_0000, instruction index loaded into the PC on reset.
REQ-002 Port: clock  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  reset is synchronous and active-low.
REQ-004 Port: io_stall  in  1  while high, no new instruction-memory request is issued.
REQ-005 Port: io_IP  out  32  current PC; drives the branch-target stage's io_IP_init.
REQ-006 Port: io_next_ip  in  32  next PC from the branch-target stage's io_B_output (IP+1 or IP+imm).
REQ-007 Port: io_imem_req_valid  out  1  fetch request valid.
REQ-008 Port: io_imem_req_ready  in  1  memory accepts request.
REQ-009 Port: io_imem_addr  out  32  fetch word index; equals io_IP.
REQ-010 Port: io_imem_rsp_valid  in  1  instruction word returned.
REQ-011 Port: io_imem_rsp_data  in  32  instruction word.
REQ-012 Port: io_inst_valid  out  1  instruction available to decode.
REQ-013 Port: io_inst_ready  in  1  decode accepts instruction.
REQ-014 Port: io_inst  out  32  registered instruction word.
REQ-015 Port: io_inst_ip  out  32  PC of io_inst.
REQ-016 Port: io_inst_count  out  32  instructions retired to decode, wraps 2^32-1 -> 0.

Function
REQ-017 FSM states: FETCH, WAIT, ISSUE; one outstanding request max.
REQ-018 FETCH: io_imem_req_valid = !io_stall; on valid && io_imem_req_ready -> WAIT next cycle; otherwise stay.
REQ-019 WAIT: req_valid=0; on io_imem_rsp_valid, capture rsp_data into io_inst, PC into io_inst_ip, -> ISSUE.
REQ-020 io_imem_rsp_valid in FETCH or ISSUE is ignored (no capture, no state change).
REQ-021 ISSUE: io_inst_valid=1; io_inst/io_inst_ip stable until handshake.
REQ-022 ISSUE with io_inst_ready=1: PC <= io_next_ip (sampled that cycle), io_inst_count += 1, -> FETCH.
REQ-023 io_IP is the PC register; it changes only per REQ-022 or reset, so io_next_ip is combinationally valid throughout ISSUE.
REQ-024 io_stall affects FETCH only; never withdraws io_inst_valid or an accepted request.
REQ-025 Latency: request accepted cycle N, response cycle M>N -> io_inst_valid high from M+1; handshake cycle K -> req_valid high K+1 (if not stalled).
REQ-026 Response in same cycle as request acceptance is not supported; memory latency >= 1 cycle.
REQ-027 io_next_ip used unmodified (32-bit, wraps naturally); no alignment check.

Reset
REQ-028 reset low at rising edge: state=FETCH, PC=RESET_IP, io_inst=0, io_inst_ip=0, io_inst_count=0.
REQ-029 During reset outputs: io_imem_req_valid=0, io_inst_valid=0.
REQ-030 Reset mid-operation (WAIT/ISSUE) abandons the transaction; a late response arrives in FETCH and is dropped per REQ-020.

Structure
REQ-031 Shared package holds the FSM state enum (2-bit), XLEN=32, and RESET_IP default.
REQ-032 No sub-module; pc_fetch instantiates alongside the branch-target stage at the top level.

Verification
REQ-033 Reset release, RESET_IP=0, memory 1-cycle, decode always ready, next_ip=IP+1 -> addresses 0,1,2,3; io_inst_count=3 after third handshake.
REQ-034 Branch: at IP=5, next_ip=5+(-3) -> following io_imem_addr=2, io_inst_ip=2.
REQ-035 Decode backpressure: io_inst_ready low 4 cycles in ISSUE -> io_inst/io_inst_ip constant, req_valid=0, count unchanged.
REQ-036 io_stall high 3 cycles in FETCH -> req_valid=0 those cycles, first request on deassert, same PC.
REQ-037 Reset asserted in WAIT, response arrives 2 cycles after release -> ignored, PC=RESET_IP, count=0.
REQ-038 Count wrap: preload count 32'hFFFF_FFFF via 1 handshake from forced state -> 0.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   XLEN             : datapath width (PC, instruction word, counters)
//   RESET_IP_DEFAULT : default instruction index loaded into the PC on reset
//   fetch_state_e    : 2-bit fetch FSM encoding (FETCH -> WAIT -> ISSUE)
package pc_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_IP_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // present a request for the word at the PC
    WAIT  = 2'd1,  // request accepted, waiting for the memory response
    ISSUE = 2'd2   // instruction held for decode until it is accepted
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch.sv
// Instruction fetch stage: owns the PC, issues one instruction-memory
// request at a time, buffers the returned word and hands it to decode.
// The next PC comes from the branch-target stage, which computes it
// combinationally from io_IP.
//
// Ports
//   clock              : sole clock, rising edge
//   reset              : synchronous, active-low
//   io_stall           : holds off new memory requests while high
//   io_IP              : current PC (word index), feeds the branch-target stage
//   io_next_ip         : next PC from the branch-target stage
//   io_imem_req_valid  : fetch request valid
//   io_imem_req_ready  : memory accepts the request
//   io_imem_addr       : fetch word index (always equal to io_IP)
//   io_imem_rsp_valid  : memory returns an instruction word
//   io_imem_rsp_data   : returned instruction word
//   io_inst_valid      : instruction available to decode
//   io_inst_ready      : decode accepts the instruction
//   io_inst            : registered instruction word
//   io_inst_ip         : PC of io_inst
//   io_inst_count      : instructions handed to decode (wraps)
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_IP = RESET_IP_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_stall,
  output logic [XLEN-1:0] io_IP,
  input  logic [XLEN-1:0] io_next_ip,
  output logic            io_imem_req_valid,
  input  logic            io_imem_req_ready,
  output logic [XLEN-1:0] io_imem_addr,
  input  logic            io_imem_rsp_valid,
  input  logic [XLEN-1:0] io_imem_rsp_data,
  output logic            io_inst_valid,
  input  logic            io_inst_ready,
  output logic [XLEN-1:0] io_inst,
  output logic [XLEN-1:0] io_inst_ip,
  output logic [XLEN-1:0] io_inst_count
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] inst_ip_q;
  logic [XLEN-1:0] count_q;

  logic            req_fire;
  logic            inst_fire;

  // Both valids are gated with reset so neither handshake can be seen
  // while reset is held low, regardless of the state register contents.
  // Stall only gates the request; it never touches an instruction already
  // in ISSUE or a request already accepted.
  assign io_imem_req_valid = reset && (state == FETCH) && !io_stall;
  assign io_inst_valid     = reset && (state == ISSUE);

  assign req_fire  = io_imem_req_valid && io_imem_req_ready;
  assign inst_fire = io_inst_valid && io_inst_ready;

  assign io_IP         = pc_q;
  assign io_imem_addr  = pc_q;
  assign io_inst       = inst_q;
  assign io_inst_ip    = inst_ip_q;
  assign io_inst_count = count_q;

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values; blocking here would let a later
  // statement see a same-cycle update and create order-dependent logic.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= FETCH;
      pc_q      <= RESET_IP;
      inst_q    <= '0;
      inst_ip_q <= '0;
      count_q   <= '0;
    end else begin
      case (state)
        FETCH: begin
          // A response showing up here (e.g. from a transaction abandoned
          // by reset) is deliberately ignored.
          if (req_fire) state <= WAIT;
        end

        WAIT: begin
          if (io_imem_rsp_valid) begin
            inst_q    <= io_imem_rsp_data;
            inst_ip_q <= pc_q;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          // The PC has been stable since the request, so io_next_ip is
          // already settled for the current instruction. No alignment or
          // range check: the branch-target result is taken as is.
          if (inst_fire) begin
            pc_q    <= io_next_ip;
            count_q <= count_q + 1'b1;
            state   <= FETCH;
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule
